// File: rtl/riscv_lsu_if.sv
// Memory-bus bundle between the load/store unit and the data memory.
//   master : LSU side; drives request, write enable, word address, byte enables and store data,
//            receives read data and ack.
//   slave  : memory side; the mirror of master.
// bus_ack_in is only meaningful while bus_req_out is high.
interface riscv_lsu_if #(
   parameter int unsigned ADDR_W = 15
);
   logic              bus_req_out;
   logic              bus_we_out;
   logic [ADDR_W-1:0] bus_addr_out;
   logic [3:0]        bus_be_out;
   logic [31:0]       bus_wdata_out;
   logic [31:0]       bus_rdata_in;
   logic              bus_ack_in;

   modport master (
      output bus_req_out, bus_we_out, bus_addr_out, bus_be_out, bus_wdata_out,
      input  bus_rdata_in, bus_ack_in
   );

   modport slave (
      input  bus_req_out, bus_we_out, bus_addr_out, bus_be_out, bus_wdata_out,
      output bus_rdata_in, bus_ack_in
   );
endinterface

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: validates an access, drives one word-wide memory bus transaction,
// and formats load data for write-back.
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   start_in          : one-cycle access request (ignored while busy_out)
//   memrw_in          : 1 store, 0 load
//   funct3_in         : size/sign field from inst[14:12]
//   addr_in, wdata_in : byte address and store data
//   busy_out          : high whenever not idle
//   done_out, err_out : one-cycle completion pulse, err_out marks a failed access
//   rdata_out         : formatted load result, held until the next completion
//   err_code_out      : 01 misaligned, 10 illegal funct3, 11 timeout, 00 after success
//   bus               : memory bus (master side)
module riscv_lsu #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned TMO    = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_in,
   input  logic              memrw_in,
   input  logic [2:0]        funct3_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [31:0]       wdata_in,
   output logic              busy_out,
   output logic              done_out,
   output logic [31:0]       rdata_out,
   output logic              err_out,
   output logic [1:0]        err_code_out,
   riscv_lsu_if.master       bus
);

   localparam int unsigned CntW = (TMO < 1) ? 1 : $clog2(TMO + 1);
   localparam logic [CntW-1:0] TmoCnt = CntW'(TMO);

   typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        alo_q, alo_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        ecode_q, ecode_d;

   // Request decode
   logic        legal, misal;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;

   always_comb begin
      legal     = 1'b0;
      misal     = 1'b0;
      be_new    = 4'b1111;
      wdata_new = '0;
      if (memrw_in) begin
         legal = funct3_in inside {3'b000, 3'b001, 3'b010};
      end else begin
         legal = funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      case (funct3_in[1:0])
         2'b01:   misal = addr_in[0];
         2'b10:   misal = (addr_in[1:0] != 2'b00);
         default: misal = 1'b0;
      endcase
      if (memrw_in) begin
         case (funct3_in[1:0])
            2'b00: begin
               be_new    = 4'b0001 << addr_in[1:0];
               wdata_new = {4{wdata_in[7:0]}};
            end
            2'b01: begin
               be_new    = addr_in[1] ? 4'b1100 : 4'b0011;
               wdata_new = {2{wdata_in[15:0]}};
            end
            default: begin
               be_new    = 4'b1111;
               wdata_new = wdata_in;
            end
         endcase
      end
   end

   // Load formatting from the latched address offset and funct3
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_fmt;

   always_comb begin
      lane_byte = '0;
      case (alo_q)
         2'd0:    lane_byte = bus.bus_rdata_in[7:0];
         2'd1:    lane_byte = bus.bus_rdata_in[15:8];
         2'd2:    lane_byte = bus.bus_rdata_in[23:16];
         default: lane_byte = bus.bus_rdata_in[31:24];
      endcase
      lane_half = alo_q[1] ? bus.bus_rdata_in[31:16] : bus.bus_rdata_in[15:0];
      case (f3_q)
         3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
         3'b100:  load_fmt = {24'd0, lane_byte};
         3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
         3'b101:  load_fmt = {16'd0, lane_half};
         default: load_fmt = bus.bus_rdata_in;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      f3_d    = f3_q;
      alo_d   = alo_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ecode_d = ecode_q;
      case (state_q)
         StIdle: begin
            if (start_in) begin
               // Illegal funct3 outranks misalignment
               if (!legal) begin
                  ecode_d = 2'b10;
                  state_d = StErr;
               end else if (misal) begin
                  ecode_d = 2'b01;
                  state_d = StErr;
               end else begin
                  we_d    = memrw_in;
                  f3_d    = funct3_in;
                  alo_d   = addr_in[1:0];
                  addr_d  = {addr_in[ADDR_W-1:2], 2'b00};
                  be_d    = be_new;
                  wdata_d = memrw_in ? wdata_new : '0;
                  cnt_d   = '0;
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            // Ack is checked first so it wins over a simultaneous timeout
            if (bus.bus_ack_in) begin
               if (!we_q) begin
                  rdata_d = load_fmt;
               end
               ecode_d = 2'b00;
               state_d = StDone;
            end else if (cnt_q == TmoCnt) begin
               ecode_d = 2'b11;
               state_d = StErr;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         alo_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ecode_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         alo_q   <= alo_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ecode_q <= ecode_d;
      end
   end

   assign busy_out          = (state_q != StIdle);
   assign done_out          = (state_q == StDone) || (state_q == StErr);
   assign err_out           = (state_q == StErr);
   assign rdata_out         = rdata_q;
   assign err_code_out      = ecode_q;
   assign bus.bus_req_out   = (state_q == StReq);
   assign bus.bus_we_out    = we_q;
   assign bus.bus_addr_out  = addr_q;
   assign bus.bus_be_out    = be_q;
   assign bus.bus_wdata_out = wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

   logic        clk;
   logic        reset;
   logic        start_in;
   logic        memrw_in;
   logic [2:0]  funct3_in;
   logic [14:0] addr_in;
   logic [31:0] wdata_in;
   logic        busy_out;
   logic        done_out;
   logic [31:0] rdata_out;
   logic        err_out;
   logic [1:0]  err_code_out;

   riscv_lsu_if #(.ADDR_W(15)) bus_if ();

   riscv_lsu #(.ADDR_W(15), .TMO(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start_in     (start_in),
      .memrw_in     (memrw_in),
      .funct3_in    (funct3_in),
      .addr_in      (addr_in),
      .wdata_in     (wdata_in),
      .busy_out     (busy_out),
      .done_out     (done_out),
      .rdata_out    (rdata_out),
      .err_out      (err_out),
      .err_code_out (err_code_out),
      .bus          (bus_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [1:0]  code;
   } exp_t;

   exp_t sb_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] rdata, input logic err, input logic [1:0] code);
      exp_t e;
      e.rdata = rdata;
      e.err   = err;
      e.code  = code;
      sb_q.push_back(e);
   endtask

   // Called at the sample point where a completion is due
   task automatic pop_check(input string tag);
      exp_t e;
      chk({tag, "_done"}, {31'd0, done_out}, 32'd1);
      chk({tag, "_sb_depth"}, sb_q.size(), 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk({tag, "_rdata"}, rdata_out, e.rdata);
         chk({tag, "_err"}, {31'd0, err_out}, {31'd0, e.err});
         chk({tag, "_code"}, {30'd0, err_code_out}, {30'd0, e.code});
      end
   endtask

   // Drive a one-cycle start at a negedge; returns at the next negedge (cycle N+1)
   task automatic start_access(input logic rw, input logic [2:0] f3, input logic [14:0] a,
                               input logic [31:0] wd);
      start_in  = 1'b1;
      memrw_in  = rw;
      funct3_in = f3;
      addr_in   = a;
      wdata_in  = wd;
      @(negedge clk);
      start_in  = 1'b0;
   endtask

   // Ack in the current cycle; returns at the next negedge
   task automatic ack_now(input logic [31:0] rd);
      bus_if.bus_rdata_in = rd;
      bus_if.bus_ack_in   = 1'b1;
      @(negedge clk);
      bus_if.bus_ack_in   = 1'b0;
   endtask

   initial begin
      int n;
      reset               = 1'b0;
      start_in            = 1'b0;
      memrw_in            = 1'b0;
      funct3_in           = '0;
      addr_in             = '0;
      wdata_in            = '0;
      bus_if.bus_rdata_in = '0;
      bus_if.bus_ack_in   = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_busy", {31'd0, busy_out}, 32'd0);
      chk("rst_done", {31'd0, done_out}, 32'd0);
      chk("rst_rdata", rdata_out, 32'd0);
      chk("rst_code", {30'd0, err_code_out}, 32'd0);
      chk("rst_req", {31'd0, bus_if.bus_req_out}, 32'd0);
      chk("rst_be", {28'd0, bus_if.bus_be_out}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // LB at 3: byte 0x80 sign-extended, done in N+2
      push(32'hFFFF_FF80, 1'b0, 2'b00);
      start_access(1'b0, 3'b000, 15'h0003, 32'd0);
      chk("lb_req", {31'd0, bus_if.bus_req_out}, 32'd1);
      chk("lb_we", {31'd0, bus_if.bus_we_out}, 32'd0);
      chk("lb_addr", {17'd0, bus_if.bus_addr_out}, 32'h0);
      chk("lb_be", {28'd0, bus_if.bus_be_out}, 32'hF);
      ack_now(32'h80FF_1234);
      pop_check("lb");
      @(negedge clk);
      chk("lb_done_pulse", {31'd0, done_out}, 32'd0);
      chk("lb_idle", {31'd0, busy_out}, 32'd0);

      // LHU at 2
      push(32'h0000_8001, 1'b0, 2'b00);
      start_access(1'b0, 3'b101, 15'h0002, 32'd0);
      ack_now(32'h8001_0000);
      pop_check("lhu");
      @(negedge clk);

      // SB at 1: rdata_out held
      push(32'h0000_8001, 1'b0, 2'b00);
      start_access(1'b1, 3'b000, 15'h0001, 32'h0000_00AB);
      chk("sb_be", {28'd0, bus_if.bus_be_out}, 32'h2);
      chk("sb_wdata", bus_if.bus_wdata_out, 32'hABAB_ABAB);
      chk("sb_we", {31'd0, bus_if.bus_we_out}, 32'd1);
      ack_now(32'hFFFF_FFFF);
      pop_check("sb");
      @(negedge clk);

      // SH at 6: upper half lanes, word address 4
      push(32'h0000_8001, 1'b0, 2'b00);
      start_access(1'b1, 3'b001, 15'h0006, 32'h1234_CDEF);
      chk("sh_be", {28'd0, bus_if.bus_be_out}, 32'hC);
      chk("sh_wdata", bus_if.bus_wdata_out, 32'hCDEF_CDEF);
      chk("sh_addr", {17'd0, bus_if.bus_addr_out}, 32'h4);
      ack_now(32'd0);
      pop_check("sh");
      @(negedge clk);

      // Misaligned LW at 6: error in N+1, no bus request
      push(32'h0000_8001, 1'b1, 2'b01);
      start_access(1'b0, 3'b010, 15'h0006, 32'd0);
      chk("mis_req", {31'd0, bus_if.bus_req_out}, 32'd0);
      pop_check("mis");
      @(negedge clk);

      // Illegal load funct3
      push(32'h0000_8001, 1'b1, 2'b10);
      start_access(1'b0, 3'b011, 15'h0000, 32'd0);
      pop_check("ill_ld");
      @(negedge clk);

      // Illegal and misaligned store: illegal code wins
      push(32'h0000_8001, 1'b1, 2'b10);
      start_access(1'b1, 3'b101, 15'h0001, 32'd0);
      chk("ill_st_req", {31'd0, bus_if.bus_req_out}, 32'd0);
      pop_check("ill_st");
      @(negedge clk);

      // LH at 0xA with delayed ack; a start while busy is ignored; bus must hold
      push(32'hFFFF_8001, 1'b0, 2'b00);
      start_access(1'b0, 3'b001, 15'h000A, 32'd0);
      start_access(1'b1, 3'b010, 15'h0000, 32'h5555_5555);
      for (int i = 0; i < 2; i++) begin
         chk("lh_hold_req", {31'd0, bus_if.bus_req_out}, 32'd1);
         chk("lh_hold_we", {31'd0, bus_if.bus_we_out}, 32'd0);
         chk("lh_hold_addr", {17'd0, bus_if.bus_addr_out}, 32'h8);
         @(negedge clk);
      end
      ack_now(32'h8001_7FFF);
      pop_check("lh");
      @(negedge clk);
      chk("lh_no_second", {31'd0, busy_out}, 32'd0);

      // Ack while idle is ignored
      bus_if.bus_ack_in = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("idle_ack_done", {31'd0, done_out}, 32'd0);
         chk("idle_ack_busy", {31'd0, busy_out}, 32'd0);
      end
      bus_if.bus_ack_in = 1'b0;
      @(negedge clk);

      // Timeout with TMO=4: five request cycles then error 11
      push(32'hFFFF_8001, 1'b1, 2'b11);
      start_access(1'b0, 3'b010, 15'h000C, 32'd0);
      n = 0;
      while (bus_if.bus_req_out === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_req_cycles", n, 32'd5);
      pop_check("tmo");
      @(negedge clk);

      // Ack on the final counted cycle wins over timeout
      push(32'h1234_5678, 1'b0, 2'b00);
      start_access(1'b0, 3'b010, 15'h0010, 32'd0);
      repeat (4) @(negedge clk);
      chk("tmo_edge_req", {31'd0, bus_if.bus_req_out}, 32'd1);
      ack_now(32'h1234_5678);
      pop_check("tmo_edge");
      @(negedge clk);

      // Reset in the middle of a request; a late ack must not complete anything
      start_access(1'b0, 3'b010, 15'h0014, 32'd0);
      chk("rmid_req_before", {31'd0, bus_if.bus_req_out}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rmid_req", {31'd0, bus_if.bus_req_out}, 32'd0);
      chk("rmid_busy", {31'd0, busy_out}, 32'd0);
      chk("rmid_rdata", rdata_out, 32'd0);
      chk("rmid_addr", {17'd0, bus_if.bus_addr_out}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      bus_if.bus_rdata_in = 32'hDEAD_BEEF;
      bus_if.bus_ack_in   = 1'b1;
      @(negedge clk);
      bus_if.bus_ack_in   = 1'b0;
      repeat (3) begin
         chk("late_ack_done", {31'd0, done_out}, 32'd0);
         chk("late_ack_rdata", rdata_out, 32'd0);
         @(negedge clk);
      end

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
